writeback_queue: RTL and testbench

- Writeback stage directly upstream of the register file write port. Collects results from the ALU path and the load path and buffers them in a small in-order FIFO.
- Retires at most one result per cycle onto the register file write port (we3/a3/wd3).
- Reports pending-write hazards on the two register file read addresses so decode can stall.

---
 rtl/writeback_queue_if.sv | 57 +++++
 rtl/writeback_queue.sv | 139 +++++++++++++
 tb/tb_writeback_queue.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_queue_if.sv
// Writeback queue port bundle: producer handshakes, hazard query, regfile write.
// WBQ_FORWARD_EN adds the forwarding data outputs.
interface writeback_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            ld_valid;
    logic [AW-1:0]   ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready;
    logic            wb_hold;
    logic [AW-1:0]   q1;
    logic [AW-1:0]   q2;
    logic            pend1;
    logic            pend2;
    logic            we3;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd3;
    logic [CW-1:0]   wb_count;
`ifdef WBQ_FORWARD_EN
    logic [XLEN-1:0] fwd1_data;
    logic [XLEN-1:0] fwd2_data;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        output wb_hold, q1, q2,
        input  pend1, pend2,
`ifdef WBQ_FORWARD_EN
        input  fwd1_data, fwd2_data,
`endif
        input  we3, a3, wd3, wb_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        input  wb_hold, q1, q2,
        output pend1, pend2,
`ifdef WBQ_FORWARD_EN
        output fwd1_data, fwd2_data,
`endif
        output we3, a3, wd3, wb_count
    );
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback FIFO feeding the regfile write port, with hazard lookup.
// Optional WBQ_FORWARD_EN: youngest-match data forwarding on fwd1/fwd2.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input logic              clk,
    input logic              rst,
    writeback_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]   rd_q   [DEPTH];
    logic [AW-1:0]   rd_d   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];
    logic [PW-1:0]   wp_q, wp_d;
    logic [PW-1:0]   rp_q, rp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we3_q, we3_d;
    logic [AW-1:0]   a3_q, a3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;

    logic            full;
    logic            empty;
    logic            acc;
    logic            push;
    logic            pop;
    logic [AW-1:0]   in_rd;
    logic [XLEN-1:0] in_data;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] m1;
    logic [DEPTH-1:0] m2;

    always_comb begin
        full    = (cnt_q == CW'(DEPTH));
        empty   = (cnt_q == '0);
        in_rd   = bus.ld_valid ? bus.ld_rd : bus.alu_rd;
        in_data = bus.ld_valid ? bus.ld_data : bus.alu_data;
        acc     = (bus.ld_valid | bus.alu_valid) & !full;
        // x0 results finish the handshake but never occupy a slot
        push    = acc & (in_rd != '0);
        pop     = !bus.wb_hold & !empty;
    end

    assign bus.ld_ready  = !full;
    assign bus.alu_ready = !full & !bus.ld_valid;

    always_comb begin
        rd_d   = rd_q;
        data_d = data_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        we3_d  = 1'b0;
        a3_d   = a3_q;
        wd3_d  = wd3_q;
        if (push) begin
            rd_d[wp_q]   = in_rd;
            data_d[wp_q] = in_data;
            wp_d         = wp_q + PW'(1);
        end
        if (pop) begin
            we3_d = 1'b1;
            a3_d  = rd_q[rp_q];
            wd3_d = data_q[rp_q];
            rp_d  = rp_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else begin
            rd_q   <= rd_d;
            data_q <= data_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            we3_q  <= we3_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
        end
    end

    // slot i is live when its distance from the read pointer is below count
    always_comb begin
        live = '0;
        m1   = '0;
        m2   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = CW'(PW'(PW'(i) - rp_q)) < cnt_q;
            m1[i]   = live[i] & (rd_q[i] == bus.q1);
            m2[i]   = live[i] & (rd_q[i] == bus.q2);
        end
        bus.pend1 = (bus.q1 != '0) &
                    ((|m1) | (we3_q & (a3_q == bus.q1)));
        bus.pend2 = (bus.q2 != '0) &
                    ((|m2) | (we3_q & (a3_q == bus.q2)));
    end

    assign bus.we3      = we3_q;
    assign bus.a3       = a3_q;
    assign bus.wd3      = wd3_q;
    assign bus.wb_count = cnt_q;

`ifdef WBQ_FORWARD_EN
    logic [XLEN-1:0] f1;
    logic [XLEN-1:0] f2;
    logic [PW-1:0]   idx;

    // walk oldest to newest so the youngest match wins
    always_comb begin
        f1  = (we3_q && a3_q == bus.q1) ? wd3_q : '0;
        f2  = (we3_q && a3_q == bus.q2) ? wd3_q : '0;
        idx = rp_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rp_q + PW'(k);
            if (CW'(k) < cnt_q && rd_q[idx] == bus.q1)
                f1 = data_q[idx];
            if (CW'(k) < cnt_q && rd_q[idx] == bus.q2)
                f2 = data_q[idx];
        end
        bus.fwd1_data = (bus.q1 != '0) ? f1 : '0;
        bus.fwd2_data = (bus.q2 != '0) ? f2 : '0;
    end
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue.
// Forwarding checks compile in only with WBQ_FORWARD_EN.
module tb_writeback_queue;
    logic clk;
    logic rst;
    int   total;
    int   passed;

    writeback_queue_if #(.DEPTH(4), .XLEN(32), .AW(5)) bus ();

    writeback_queue #(.DEPTH(4), .XLEN(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = '0;
        bus.ld_data   = '0;
        bus.wb_hold   = 1'b0;
        bus.q1        = '0;
        bus.q2        = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd3;
        bus.ld_data  = 32'h33;
        tick();
        tick();
        total++;
        if (bus.we3 !== 1'b0 || bus.wb_count !== 3'd0)
            $display("FAIL rst_hold we3=%b cnt=%0d want 0/0",
                     bus.we3, bus.wb_count);
        else passed++;
        total++;
        if (bus.a3 !== 5'd0 || bus.wd3 !== 32'd0)
            $display("FAIL rst_regs a3=%0d wd3=%h want 0/0",
                     bus.a3, bus.wd3);
        else passed++;
        total++;
        if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b0)
            $display("FAIL rst_ready ld=%b alu=%b want 1/0",
                     bus.ld_ready, bus.alu_ready);
        else passed++;
        rst = 1'b1;
        bus.wb_hold = 1'b1;
        tick();
        total++;
        if (bus.wb_count !== 3'd1)
            $display("FAIL rst_first_acc cnt=%0d want 1", bus.wb_count);
        else passed++;
        tick();
        tick();
        bus.ld_valid = 1'b0;
        total++;
        if (bus.wb_count !== 3'd3)
            $display("FAIL rst_fill cnt=%0d want 3", bus.wb_count);
        else passed++;
        #2 rst = 1'b0;
        #1;
        total++;
        if (bus.we3 !== 1'b0 || bus.wb_count !== 3'd0)
            $display("FAIL rst_async we3=%b cnt=%0d want 0/0",
                     bus.we3, bus.wb_count);
        else passed++;
        tick();
        rst = 1'b1;
        bus.wb_hold = 1'b0;
        tick();
        total++;
        if (bus.we3 !== 1'b0 || bus.wb_count !== 3'd0)
            $display("FAIL rst_discard we3=%b cnt=%0d want 0/0",
                     bus.we3, bus.wb_count);
        else passed++;
    endtask

    task automatic test_single_alu();
        idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        tick();
        bus.alu_valid = 1'b0;
        total++;
        if (bus.we3 !== 1'b0 || bus.wb_count !== 3'd1)
            $display("FAIL alu_acc we3=%b cnt=%0d want 0/1",
                     bus.we3, bus.wb_count);
        else passed++;
        tick();
        total++;
        if (bus.we3 !== 1'b1 || bus.a3 !== 5'd5 ||
            bus.wd3 !== 32'hDEADBEEF)
            $display("FAIL alu_ret we3=%b a3=%0d wd3=%h want 1/5/deadbeef",
                     bus.we3, bus.a3, bus.wd3);
        else passed++;
        tick();
        total++;
        if (bus.we3 !== 1'b0 || bus.a3 !== 5'd5)
            $display("FAIL alu_once we3=%b a3=%0d want 0/5",
                     bus.we3, bus.a3);
        else passed++;
    endtask

    task automatic test_priority();
        idle();
        bus.q1        = 5'd7;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd7;
        bus.alu_data  = 32'h11;
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd7;
        bus.ld_data   = 32'h22;
        #1;
        total++;
        if (bus.alu_ready !== 1'b0 || bus.ld_ready !== 1'b1)
            $display("FAIL prio_ready alu=%b ld=%b want 0/1",
                     bus.alu_ready, bus.ld_ready);
        else passed++;
        tick();
        bus.ld_valid = 1'b0;
        #1;
        total++;
        if (bus.alu_ready !== 1'b1 || bus.pend1 !== 1'b1)
            $display("FAIL prio_second alu_rdy=%b pend1=%b want 1/1",
                     bus.alu_ready, bus.pend1);
        else passed++;
        tick();
        bus.alu_valid = 1'b0;
        total++;
        if (bus.we3 !== 1'b1 || bus.wd3 !== 32'h22)
            $display("FAIL prio_first we3=%b wd3=%h want 1/22",
                     bus.we3, bus.wd3);
        else passed++;
        tick();
        total++;
        if (bus.we3 !== 1'b1 || bus.wd3 !== 32'h11 || bus.pend1 !== 1'b1)
            $display("FAIL prio_next we3=%b wd3=%h pend1=%b want 1/11/1",
                     bus.we3, bus.wd3, bus.pend1);
        else passed++;
        tick();
        total++;
        if (bus.we3 !== 1'b0 || bus.pend1 !== 1'b0)
            $display("FAIL prio_clear we3=%b pend1=%b want 0/0",
                     bus.we3, bus.pend1);
        else passed++;
    endtask

    task automatic test_full_hold();
        idle();
        bus.wb_hold  = 1'b1;
        bus.ld_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.ld_rd   = 5'(i);
            bus.ld_data = 32'h100 + 32'(i);
            tick();
        end
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd9;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd9;
        #1;
        total++;
        if (bus.wb_count !== 3'd4 || bus.ld_ready !== 1'b0 ||
            bus.alu_ready !== 1'b0)
            $display("FAIL full cnt=%0d ld=%b alu=%b want 4/0/0",
                     bus.wb_count, bus.ld_ready, bus.alu_ready);
        else passed++;
        tick();
        bus.ld_valid  = 1'b0;
        bus.alu_valid = 1'b0;
        total++;
        if (bus.wb_count !== 3'd4 || bus.we3 !== 1'b0)
            $display("FAIL full_hold cnt=%0d we3=%b want 4/0",
                     bus.wb_count, bus.we3);
        else passed++;
        bus.wb_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if (bus.we3 !== 1'b1 || bus.a3 !== 5'(i) ||
                bus.wd3 !== 32'h100 + 32'(i) || bus.ld_ready !== 1'b1)
                $display("FAIL drain%0d we3=%b a3=%0d wd3=%h rdy=%b",
                         i, bus.we3, bus.a3, bus.wd3, bus.ld_ready);
            else passed++;
        end
        tick();
        total++;
        if (bus.we3 !== 1'b0 || bus.wb_count !== 3'd0)
            $display("FAIL drain_end we3=%b cnt=%0d want 0/0",
                     bus.we3, bus.wb_count);
        else passed++;
    endtask

    task automatic test_push_pop();
        idle();
        bus.wb_hold  = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd6;
        bus.ld_data  = 32'h66;
        tick();
        bus.wb_hold = 1'b0;
        bus.ld_rd   = 5'd7;
        bus.ld_data = 32'h77;
        tick();
        bus.ld_valid = 1'b0;
        total++;
        if (bus.wb_count !== 3'd1 || bus.a3 !== 5'd6 || bus.we3 !== 1'b1)
            $display("FAIL pushpop cnt=%0d a3=%0d we3=%b want 1/6/1",
                     bus.wb_count, bus.a3, bus.we3);
        else passed++;
        tick();
        total++;
        if (bus.wb_count !== 3'd0 || bus.wd3 !== 32'h77)
            $display("FAIL pushpop2 cnt=%0d wd3=%h want 0/77",
                     bus.wb_count, bus.wd3);
        else passed++;
        tick();
    endtask

    task automatic test_x0_hazard();
        idle();
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd0;
        bus.ld_data  = 32'hFFFF_FFFF;
        tick();
        bus.ld_valid = 1'b0;
        total++;
        if (bus.wb_count !== 3'd0 || bus.pend1 !== 1'b0)
            $display("FAIL x0_drop cnt=%0d pend1=%b want 0/0",
                     bus.wb_count, bus.pend1);
        else passed++;
        tick();
        total++;
        if (bus.we3 !== 1'b0)
            $display("FAIL x0_nowrite we3=%b want 0", bus.we3);
        else passed++;
        bus.wb_hold  = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd9;
        bus.ld_data  = 32'h99;
        tick();
        bus.ld_valid = 1'b0;
        bus.q2 = 5'd9;
        bus.q1 = 5'd8;
        #1;
        total++;
        if (bus.pend2 !== 1'b1 || bus.pend1 !== 1'b0)
            $display("FAIL haz_q pend2=%b pend1=%b want 1/0",
                     bus.pend2, bus.pend1);
        else passed++;
        bus.q1 = 5'd0;
        #1;
        total++;
        if (bus.pend1 !== 1'b0)
            $display("FAIL haz_x0 pend1=%b want 0", bus.pend1);
        else passed++;
        bus.wb_hold = 1'b0;
        tick();
        total++;
        if (bus.pend2 !== 1'b1 || bus.we3 !== 1'b1)
            $display("FAIL haz_outreg pend2=%b we3=%b want 1/1",
                     bus.pend2, bus.we3);
        else passed++;
        tick();
        total++;
        if (bus.pend2 !== 1'b0)
            $display("FAIL haz_clear pend2=%b want 0", bus.pend2);
        else passed++;
    endtask

    task automatic test_forward();
        idle();
        bus.wb_hold  = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd4;
        bus.ld_data  = 32'hA;
        tick();
        bus.ld_data  = 32'hB;
        tick();
        bus.ld_valid = 1'b0;
        bus.q1 = 5'd4;
        #1;
        total++;
        if (bus.pend1 !== 1'b1 || bus.we3 !== 1'b0)
            $display("FAIL fwd_pend pend1=%b we3=%b want 1/0",
                     bus.pend1, bus.we3);
        else passed++;
`ifdef WBQ_FORWARD_EN
        total++;
        if (bus.fwd1_data !== 32'hB || bus.fwd2_data !== 32'h0)
            $display("FAIL fwd_young fwd1=%h fwd2=%h want b/0",
                     bus.fwd1_data, bus.fwd2_data);
        else passed++;
`endif
        bus.wb_hold = 1'b0;
        tick();
        total++;
        if (bus.we3 !== 1'b1 || bus.wd3 !== 32'hA || bus.pend1 !== 1'b1)
            $display("FAIL fwd_r1 we3=%b wd3=%h pend1=%b want 1/a/1",
                     bus.we3, bus.wd3, bus.pend1);
        else passed++;
`ifdef WBQ_FORWARD_EN
        total++;
        if (bus.fwd1_data !== 32'hB)
            $display("FAIL fwd_fifo fwd1=%h want b", bus.fwd1_data);
        else passed++;
`endif
        tick();
        total++;
        if (bus.we3 !== 1'b1 || bus.wd3 !== 32'hB || bus.pend1 !== 1'b1)
            $display("FAIL fwd_r2 we3=%b wd3=%h pend1=%b want 1/b/1",
                     bus.we3, bus.wd3, bus.pend1);
        else passed++;
`ifdef WBQ_FORWARD_EN
        total++;
        if (bus.fwd1_data !== 32'hB)
            $display("FAIL fwd_outreg fwd1=%h want b", bus.fwd1_data);
        else passed++;
`endif
        tick();
        total++;
        if (bus.we3 !== 1'b0 || bus.pend1 !== 1'b0)
            $display("FAIL fwd_end we3=%b pend1=%b want 0/0",
                     bus.we3, bus.pend1);
        else passed++;
`ifdef WBQ_FORWARD_EN
        total++;
        if (bus.fwd1_data !== 32'h0)
            $display("FAIL fwd_zero fwd1=%h want 0", bus.fwd1_data);
        else passed++;
`endif
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b0;
        idle();
        test_reset();
        test_single_alu();
        test_priority();
        test_full_hold();
        test_push_pop();
        test_x0_hazard();
        test_forward();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
